// File: rtl/up_counter.sv
// Modulo-MODULUS up-counter with enable, parallel load, terminal-count and wrap decode.
// Latency: count updates one clk edge after en/load; tc and wrap decode count combinationally.
// No backpressure; optional sticky overflow flag ovf under UP_COUNTER_OVF_STICKY_EN.
module up_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
`ifdef UP_COUNTER_OVF_STICKY_EN
    output logic             ovf,
`endif
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    // Out-of-range load values fall back to zero; the extra bit makes MODULUS == 2**WIDTH legal.
    logic load_ok;
    assign load_ok = ({1'b0, load_val} < MOD_EXT);

    assign tc   = (count == LAST);
    assign wrap = tc & en & ~load & reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_ok ? load_val : '0;
        end else if (en) begin
            count <= tc ? '0 : count + WIDTH'(1);
        end
    end

`ifdef UP_COUNTER_OVF_STICKY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf <= 1'b0;
        end else if (load) begin
            ovf <= 1'b0;
        end else if (wrap) begin
            ovf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_up_counter.sv
// Drives a default (mod 16) and a mod-10 up_counter side by side against an arithmetic model.
module tb_up_counter;

    localparam int MA = 16;
    localparam int MB = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] count_a, count_b;
    logic       tc_a, tc_b, wrap_a, wrap_b;
`ifdef UP_COUNTER_OVF_STICKY_EN
    logic       ovf_a, ovf_b;
`endif

    int compared   = 0;
    int mismatched = 0;
    int mc[2];
    bit mo[2];
    int mods[2] = '{MA, MB};

    always #5 clk = ~clk;

    up_counter #(.WIDTH(4), .MODULUS(MA)) dut_a (
        .clk(clk), .reset(rst), .en(en), .load(load), .load_val(load_val),
        .count(count_a), .tc(tc_a),
`ifdef UP_COUNTER_OVF_STICKY_EN
        .ovf(ovf_a),
`endif
        .wrap(wrap_a)
    );

    up_counter #(.WIDTH(4), .MODULUS(MB)) dut_b (
        .clk(clk), .reset(rst), .en(en), .load(load), .load_val(load_val),
        .count(count_b), .tc(tc_b),
`ifdef UP_COUNTER_OVF_STICKY_EN
        .ovf(ovf_b),
`endif
        .wrap(wrap_b)
    );

    task automatic check(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int  c[2];
        bit  t[2];
        bit  w[2];
        bit  o[2];
        c[0] = int'(count_a); t[0] = tc_a; w[0] = wrap_a;
        c[1] = int'(count_b); t[1] = tc_b; w[1] = wrap_b;
        o[0] = 1'b0; o[1] = 1'b0;
`ifdef UP_COUNTER_OVF_STICKY_EN
        o[0] = ovf_a; o[1] = ovf_b;
`endif
        for (int i = 0; i < 2; i++) begin
            bit et;
            bit ew;
            et = (mc[i] == mods[i] - 1);
            ew = et && en && !load && rst;
            check($sformatf("%s/m%0d/count", tag, mods[i]), c[i], mc[i]);
            check($sformatf("%s/m%0d/tc", tag, mods[i]), int'(t[i]), int'(et));
            check($sformatf("%s/m%0d/wrap", tag, mods[i]), int'(w[i]), int'(ew));
`ifdef UP_COUNTER_OVF_STICKY_EN
            check($sformatf("%s/m%0d/ovf", tag, mods[i]), int'(o[i]), int'(mo[i]));
`else
            if (o[i]) mismatched += 0;
`endif
        end
    endtask

    // One clock period: apply inputs after the falling edge, check, then advance the model at the rising edge.
    task automatic cycle(input string tag, input bit r, input bit e, input bit l, input int lv);
        bit wr[2];
        @(negedge clk);
        rst      = r;
        en       = e;
        load     = l;
        load_val = 4'(lv);
        if (!r) begin
            mc[0] = 0; mc[1] = 0; mo[0] = 0; mo[1] = 0;
        end
        #1;
        check_all(tag);
        for (int i = 0; i < 2; i++)
            wr[i] = (mc[i] == mods[i] - 1) && e && !l && r;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 2; i++) begin
                if (l) begin
                    mc[i] = (lv < mods[i]) ? lv : 0;
                    mo[i] = 0;
                end else if (e) begin
                    mc[i] = (mc[i] + 1) % mods[i];
                    if (wr[i]) mo[i] = 1;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; load = 1'b0; load_val = 4'd0;
        mc[0] = 0; mc[1] = 0; mo[0] = 0; mo[1] = 0;
        #2;
        check("reset_t0_count_a", int'(count_a), 0);
        check("reset_t0_count_b", int'(count_b), 0);

        for (int k = 0; k < 3; k++) cycle("reset_held", 0, 1, 0, 0);

        // Release, then free-run past a wrap of both counters.
        for (int k = 0; k < 22; k++) cycle("run", 1, 1, 0, 0);

        // Load priority at terminal count.
        cycle("ld15", 1, 0, 1, 15);
        cycle("at15", 1, 1, 1, 5);
        cycle("after_ld5", 1, 1, 0, 0);
        cycle("ld12", 1, 1, 1, 12);
        cycle("after_ld12", 1, 0, 0, 0);

        // Enable gating.
        cycle("ld7", 1, 0, 1, 7);
        for (int k = 0; k < 3; k++) cycle("hold", 1, 0, 0, 0);
        cycle("en_again", 1, 1, 0, 0);
        cycle("en_again2", 1, 1, 0, 0);

        // Asynchronous reset mid-count, asserted between edges.
        cycle("ld9", 1, 0, 1, 9);
        cycle("pre_rst", 1, 1, 0, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_count_a", int'(count_a), 0);
        check("async_rst_count_b", int'(count_b), 0);
        mc[0] = 0; mc[1] = 0; mo[0] = 0; mo[1] = 0;
        cycle("rst_hold1", 0, 1, 1, 3);
        cycle("rst_hold2", 0, 1, 0, 0);
        for (int k = 0; k < 4; k++) cycle("resume", 1, 1, 0, 0);

        // Randomised traffic.
        for (int k = 0; k < 400; k++) begin
            bit r, e, l;
            r = ($urandom_range(0, 39) != 0);
            e = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 9) == 0);
            cycle("rand", r, e, l, int'($urandom_range(0, 15)));
        end
        cycle("final", 1, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
